// File: rtl/reg_file_pkg.sv
// Shared register-file definitions: default widths, bank size and the write-request record.
package reg_file_pkg;

    localparam int REG_DATA_WIDTH = 32;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int NUM_REGS       = 2 ** REG_ADDR_WIDTH;

    typedef struct packed {
        logic [REG_ADDR_WIDTH-1:0] addr;
        logic [REG_DATA_WIDTH-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/reg_file_wr_fifo.sv
// Synchronous FIFO buffering register write requests; synchronous active-high reset.
module reg_file_wr_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             push_s;
    logic             pop_s;

    assign full   = (count_r == CW'(DEPTH));
    assign empty  = (count_r == {CW{1'b0}});
    assign count  = count_r;
    assign rdata  = mem_r[rd_ptr_r];
    assign push_s = push & ~full;
    assign pop_s  = pop & ~empty;

    // Storage array; contents need no reset because occupancy guards every read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
        end else begin
            wr_ptr_r <= push_s ? wr_ptr_r + PW'(1) : wr_ptr_r;
            rd_ptr_r <= pop_s  ? rd_ptr_r + PW'(1) : rd_ptr_r;
        end
    end

    // Occupancy counter; simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= {CW{1'b0}};
        end else begin
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/reg_file_wr_ctrl.sv
// Register-file write-port controller: FIFO-buffered requests drained into a registered
// one-hot enable and shared data bus. Optional same-cycle bypass: REG_FILE_WR_BYPASS_EN.
module reg_file_wr_ctrl
    import reg_file_pkg::*;
#(
    parameter int DATA_WIDTH = REG_DATA_WIDTH,
    parameter int ADDR_WIDTH = REG_ADDR_WIDTH,
    parameter int DEPTH      = 4,
    parameter int ZERO_REG   = 1,
    localparam int NREG      = 2 ** ADDR_WIDTH,
    localparam int CW        = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  hold,
    output logic [NREG-1:0]       reg_en,
    output logic [DATA_WIDTH-1:0] reg_d,
    output logic [CW-1:0]         wr_count
);

    localparam int EW = ADDR_WIDTH + DATA_WIDTH;

    logic [EW-1:0]         fifo_rdata_s;
    logic                  fifo_full_s;
    logic                  fifo_empty_s;
    logic                  fifo_push_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  bypass_s;
    logic [ADDR_WIDTH-1:0] head_addr_s;
    logic [DATA_WIDTH-1:0] head_data_s;
    logic [NREG-1:0]       en_nxt_s;
    logic [DATA_WIDTH-1:0] d_nxt_s;
    logic [NREG-1:0]       reg_en_r;
    logic [DATA_WIDTH-1:0] reg_d_r;

    function automatic logic [NREG-1:0] decode(input logic [ADDR_WIDTH-1:0] addr);
        logic [NREG-1:0] v;
        v = {NREG{1'b0}};
        if ((ZERO_REG != 0) && (addr == {ADDR_WIDTH{1'b0}})) begin
            v = {NREG{1'b0}};
        end else begin
            v[addr] = 1'b1;
        end
        return v;
    endfunction

    // Readiness ignores a same-cycle pop, so a full FIFO never pushes through.
    assign wr_ready    = ~reset & ~fifo_full_s;
    assign push_s      = wr_valid & wr_ready;
    assign pop_s       = ~fifo_empty_s & ~hold;
    assign head_addr_s = fifo_rdata_s[DATA_WIDTH +: ADDR_WIDTH];
    assign head_data_s = fifo_rdata_s[DATA_WIDTH-1:0];

`ifdef REG_FILE_WR_BYPASS_EN
    assign bypass_s    = push_s & fifo_empty_s & ~hold;
`else
    assign bypass_s    = 1'b0;
`endif
    assign fifo_push_s = push_s & ~bypass_s;

    reg_file_wr_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push_s),
        .pop   (pop_s),
        .wdata ({wr_addr, wr_data}),
        .rdata (fifo_rdata_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (wr_count)
    );

    // Next enable/data: pop and bypass are exclusive because bypass needs an empty FIFO.
    always_comb begin
        en_nxt_s = {NREG{1'b0}};
        d_nxt_s  = reg_d_r;
        if (pop_s) begin
            en_nxt_s = decode(head_addr_s);
            d_nxt_s  = head_data_s;
        end else if (bypass_s) begin
            en_nxt_s = decode(wr_addr);
            d_nxt_s  = wr_data;
        end else begin
            en_nxt_s = {NREG{1'b0}};
            d_nxt_s  = reg_d_r;
        end
    end

    // Output registers feeding the bank's enable and D inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            reg_en_r <= {NREG{1'b0}};
            reg_d_r  <= {DATA_WIDTH{1'b0}};
        end else begin
            reg_en_r <= en_nxt_s;
            reg_d_r  <= d_nxt_s;
        end
    end

    assign reg_en = reg_en_r;
    assign reg_d  = reg_d_r;

endmodule

// File: tb/tb_reg_file_wr_ctrl.sv
// Self-checking bench for reg_file_wr_ctrl: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_reg_file_wr_ctrl;
    import reg_file_pkg::*;

    localparam int DEPTH = 4;

    logic        clk;
    logic        reset;
    logic        wr_valid;
    logic        wr_ready;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        hold;
    logic [31:0] reg_en;
    logic [31:0] reg_d;
    logic [2:0]  wr_count;

    int checks = 0;
    int errors = 0;

    wr_req_t     q[$];
    logic [31:0] m_en;
    logic [31:0] m_d;
    logic [31:0] seen[$];

    reg_file_wr_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .DEPTH(DEPTH), .ZERO_REG(1)) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .hold     (hold),
        .reg_en   (reg_en),
        .reg_d    (reg_d),
        .wr_count (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] enc(input logic [4:0] a);
        logic [31:0] one;
        one = 32'd1;
        return (a == 5'd0) ? 32'd0 : (one << a);
    endfunction

    // One clock: drive inputs, check readiness, clock, advance the model, check outputs.
    task automatic step(input logic v, input logic [4:0] a, input logic [31:0] d,
                        input logic h, input logic r);
        logic    exp_ready;
        logic    acc;
        logic    byp;
        wr_req_t item;
        wr_valid = v; wr_addr = a; wr_data = d; hold = h; reset = r;
        #1;
        exp_ready = !r && (q.size() < DEPTH);
        chk("wr_ready", {63'd0, wr_ready}, {63'd0, exp_ready});
        acc = v && exp_ready;
        @(posedge clk);
        if (r) begin
            q.delete();
            m_en = 32'd0;
            m_d  = 32'd0;
        end else begin
            byp = 1'b0;
`ifdef REG_FILE_WR_BYPASS_EN
            byp = acc && (q.size() == 0) && !h;
`endif
            if (q.size() > 0 && !h) begin
                item = q.pop_front();
                m_en = enc(item.addr);
                m_d  = item.data;
            end else if (byp) begin
                m_en = enc(a);
                m_d  = d;
            end else begin
                m_en = 32'd0;
            end
            if (acc && !byp) q.push_back('{addr: a, data: d});
        end
        #1;
        chk("reg_en",   {32'd0, reg_en}, {32'd0, m_en});
        chk("reg_d",    {32'd0, reg_d},  {32'd0, m_d});
        chk("wr_count", {61'd0, wr_count}, 64'(q.size()));
        chk("onehot",   64'($countones(reg_en) <= 1), 64'd1);
        if (reg_en != 32'd0) seen.push_back(reg_en);
    endtask

    initial begin
        int maxc;
        wr_valid = 1'b0; wr_addr = 5'd0; wr_data = 32'd0; hold = 1'b0; reset = 1'b1;
        m_en = 32'd0; m_d = 32'd0;

        // Reset held two cycles with a pending request.
        step(1'b1, 5'd3, 32'h1111_1111, 1'b0, 1'b1);
        step(1'b1, 5'd3, 32'h1111_1111, 1'b0, 1'b1);
        chk("rst_en",    {32'd0, reg_en}, 64'd0);
        chk("rst_d",     {32'd0, reg_d},  64'd0);
        chk("rst_count", {61'd0, wr_count}, 64'd0);
        chk("rst_ready", {63'd0, wr_ready}, 64'd0);
        reset = 1'b0; wr_valid = 1'b0;
        #1;
        chk("ready_after_rst", {63'd0, wr_ready}, 64'd1);

        // Single write: one 0x20 pulse, one cycle later without bypass.
        step(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 1'b0);
`ifdef REG_FILE_WR_BYPASS_EN
        chk("single_e0", {32'd0, reg_en}, 64'h20);
`else
        chk("single_e0", {32'd0, reg_en}, 64'h0);
`endif
        step(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
`ifdef REG_FILE_WR_BYPASS_EN
        chk("single_e1", {32'd0, reg_en}, 64'h0);
`else
        chk("single_e1", {32'd0, reg_en}, 64'h20);
`endif
        chk("single_d", {32'd0, reg_d}, 64'hDEAD_BEEF);
        step(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        chk("single_end", {32'd0, reg_en}, 64'h0);

        // Fill under hold, stall a fifth request, then release.
        for (int i = 1; i <= 4; i++) step(1'b1, 5'(i), 32'(i * 16), 1'b1, 1'b0);
        chk("fill_count", {61'd0, wr_count}, 64'd4);
        chk("fill_ready", {63'd0, wr_ready}, 64'd0);
        step(1'b1, 5'd9, 32'h9999, 1'b1, 1'b0);
        chk("fill_stall", {61'd0, wr_count}, 64'd4);
        for (int i = 1; i <= 4; i++) begin
            step(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
            chk("drain_en", {32'd0, reg_en}, 64'd1 << i);
        end

        // Zero register is consumed silently; addr 7 follows.
        seen.delete();
        step(1'b1, 5'd0, 32'hAAAA, 1'b0, 1'b0);
        step(1'b1, 5'd7, 32'hBBBB, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        chk("zero_pulses", 64'(seen.size()), 64'd1);
        if (seen.size() > 0) chk("zero_en7", {32'd0, seen[0]}, 64'h80);
        chk("zero_count", {61'd0, wr_count}, 64'd0);

        // Back-to-back streaming of 8 writes.
        seen.delete();
        maxc = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 5'(8 + i), 32'(i), 1'b0, 1'b0);
            if (int'(wr_count) > maxc) maxc = int'(wr_count);
        end
        for (int i = 0; i < 3; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        chk("stream_maxcount", 64'(maxc), 64'd1);
        chk("stream_pulses", 64'(seen.size()), 64'd8);
        for (int i = 0; i < 8 && i < seen.size(); i++)
            chk("stream_order", {32'd0, seen[i]}, 64'd1 << (8 + i));

        // Reset with three entries buffered.
        for (int i = 0; i < 3; i++) step(1'b1, 5'(20 + i), 32'(i), 1'b1, 1'b0);
        chk("mid_count_pre", {61'd0, wr_count}, 64'd3);
        step(1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
        chk("mid_count", {61'd0, wr_count}, 64'd0);
        chk("mid_en", {32'd0, reg_en}, 64'd0);
        seen.delete();
        for (int i = 0; i < 3; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        chk("mid_no_stale", 64'(seen.size()), 64'd0);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 99) < 70), 5'($urandom), $urandom,
                 1'($urandom_range(0, 99) < 30), 1'($urandom_range(0, 99) < 2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_file_wr_ctrl.md
# reg_file_wr_ctrl

Write-port controller that sits directly upstream of the register file's per-register enable flip-flops. It accepts register write requests over a valid/ready handshake and buffers them in a small FIFO. It drains at most one request per cycle into a registered one-hot enable vector plus a shared data bus, which drive the `enable`/`D` inputs of the register bank. A `hold` input freezes draining, for example during register-file scan or read-port priority, without losing requests.

## Interface
Parameters:
- DATA_WIDTH, 32, width of register data
- ADDR_WIDTH, 5, register index width; bank has 2**ADDR_WIDTH registers
- DEPTH, 4, FIFO entries; power of two, ≥2
- ZERO_REG, 1, when 1, writes to index 0 are discarded (no enable pulse)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  rising-edge clock for all state
- reset  in  1  synchronous, active-high; sampled only on rising clk
- wr_valid  in  1  write request present
- wr_ready  out  1  FIFO can accept; transfer occurs when wr_valid & wr_ready at a rising edge
- wr_addr  in  ADDR_WIDTH  target register index
- wr_data  in  DATA_WIDTH  write data
- hold  in  1  when 1, no entry is popped this cycle
- reg_en  out  2**ADDR_WIDTH  registered one-hot write enable to the bank
- reg_d  out  DATA_WIDTH  registered write data, shared by all registers
- wr_count  out  $clog2(DEPTH)+1  current FIFO occupancy

## Operation
- Reset values after a reset edge: FIFO empty, wr_count=0, reg_en=0, reg_d=0. wr_ready=0 while reset=1.
- wr_ready = !reset && (wr_count < DEPTH). It does not depend on a same-cycle pop, so there is no push-through when full.
- Push: on wr_valid & wr_ready, {wr_addr, wr_data} is written at the write pointer, and the pointer increments modulo DEPTH.
- Pop: when wr_count>0 and hold=0, the head entry is read and the read pointer increments modulo DEPTH.
- Pop on the next edge:
  - reg_d ← head data.
  - reg_en ← one-hot(head addr).
  - If ZERO_REG=1 and head addr=0, then reg_en ← 0. The entry is still consumed.
- No pop: reg_en ← 0 on the next edge, and reg_d holds its previous value.
- Simultaneous push and pop: wr_count unchanged, both pointers advance.
- Requests are drained in strict arrival order. Two writes to the same index both pulse in order, so the later one wins in the bank.
- Reset mid-operation discards all buffered entries, and reg_en is 0 from the edge where reset is sampled.
- reg_en has at most one bit set in any cycle.

## Timing
- Push at edge E into an empty FIFO with hold=0:
  - pop at E+1.
  - reg_en/reg_d valid during cycle E+1..E+2.
  - bank captures at E+2.
- Total latency from accept to bank update is 2 cycles (1 with bypass).
- Sustained throughput is 1 write/cycle while hold=0.
- hold asserted for N cycles delays each pending write by N cycles. Entries keep accumulating until wr_count=DEPTH.
- wr_count is updated at every edge and is valid the cycle after.

## Configuration
- Macro: REG_FILE_WR_BYPASS_EN.
- When defined: if wr_count=0, hold=0 and a push occurs at edge E, the request bypasses the FIFO. reg_en/reg_d are loaded at E directly (ZERO_REG rule applies), the FIFO is not written, and the bank captures at E+1.
- When undefined: every request passes through the FIFO with the 2-cycle latency above.
- Ordering, wr_ready and occupancy rules are identical in both builds.

## Structure
- Shared package reg_file_pkg:
  - DATA_WIDTH and ADDR_WIDTH defaults, also used by the bank and read ports.
  - typedef of the write-request struct {addr, data}.
  - a NUM_REGS constant.
- Sub-module reg_file_wr_fifo, the synchronous FIFO:
  - push/pop, full/empty, count.
  - synchronous active-high reset.
- Top level holds the pop logic, the one-hot decoder, the output registers and the bypass path.

## Test plan
- Reset: drive reset=1 for 2 cycles with wr_valid=1 → wr_ready=0, reg_en=0, reg_d=0, wr_count=0. After release, wr_ready=1.
- Single write: addr=5, data=0xDEADBEEF, hold=0.
  - Without bypass: reg_en=0x20 for exactly one cycle, 2 cycles after accept, with reg_d=0xDEADBEEF.
  - With bypass: the same pulse 1 cycle after accept.
- Fill under hold: hold=1, push addrs 1,2,3,4.
  - wr_count=4, wr_ready=0, and a 5th request stalls.
  - Release hold → reg_en pulses 0x2, 0x4, 0x8, 0x10 on consecutive cycles.
- Zero register: ZERO_REG=1, push addr=0 then addr=7 → no pulse for addr 0, then reg_en=0x80, and wr_count returns to 0.
- Back-to-back streaming: push 8 writes on consecutive cycles with hold=0 → wr_count never exceeds 1, and 8 consecutive one-hot pulses appear in order.
- Reset mid-operation: 3 entries buffered, then reset asserted → next cycle wr_count=0 and reg_en=0, and no stale pulse appears after release.
